char_bitmap_server: RTL and testbench
=====================================

# char_bitmap_server

Responder side of the character-draw read interface: accepts the `readEn`/`rowCnt`/`colCnt` requests issued by the character positioning logic, fetches the addressed glyph row from an external synchronous font ROM, buffers it, and returns the per-pixel `bitDisp` bit. It sits between the VGA character handler and the font ROM. It hides ROM latency behind a request FSM, queues at most one pending request, and flags overruns.

## Interface
Parameters:
- `ROM_LATENCY`, 1: clock edges from the ROM sampling `romAddr` to `romData` being valid (range 1..4).
- `CHAR_ROWS`, 12: glyph height in rows; rows at or beyond this index are blank.

Ports:
- `clock`  in  1  system/pixel clock; one clock domain.
- `reset`  in  1  asynchronous, active-high.
- `readEn`  in  1  one-cycle request strobe for a new glyph row.
- `rowCnt`  in  4  glyph row index for the request.
- `colCnt`  in  3  pixel column within the current glyph row; 0 = leftmost.
- `charCode`  in  7  character to draw, sampled with `readEn`.
- `invert`  in  1  when 1, `bitDisp` is the complement of the glyph bit (valid rows only).
- `romData`  in  8  font ROM row data; bit 7 = leftmost pixel.
- `romRd`  out  1  ROM read strobe.
- `romAddr`  out  11  ROM address `{charCode, rowCnt}`.
- `bitDisp`  out  1  pixel-on bit for the current `colCnt`.
- `rowValid`  out  1  active row buffer holds fetched data.
- `overrun`  out  1  sticky: a request was lost.

## Operation
- Reset values: `romRd`=0, `romAddr`=0, `rowValid`=0, `overrun`=0, active row=0, pending slot empty, FSM in IDLE. `bitDisp`=0.
- Request capture: on a clock edge with `readEn`=1, latch `charCode` and `rowCnt` as a request.
- Blank requests need no ROM access: `charCode`==0 or `rowCnt` >= `CHAR_ROWS`. They complete the following cycle with active row = 8'h00 and `rowValid`=1. `invert` does not apply to blank rows.
- FSM states:
  - IDLE: if a request is accepted or pending, go to ISSUE. A blank request loads directly and stays in IDLE.
  - ISSUE: `romRd`=1 for exactly one cycle with `romAddr` registered. Next state is WAIT.
  - WAIT: count `ROM_LATENCY` edges.
  - LOAD: `romData` is written into the active row and `rowValid`=1. Then go to ISSUE if a request is pending, otherwise IDLE.
- Pending slot is 1 deep. A `readEn` while the FSM is not in IDLE is stored there. A `readEn` while the slot is already full overwrites the slot (newest wins) and sets `overrun`=1. `overrun` clears only on `reset`.
- A request that completes replaces the active row atomically. `rowValid` stays 1 across replacements.
- `bitDisp` is combinational: `rowValid & (activeRow[7-colCnt] ^ (invert & ~blankRow))`.

## Timing
- `readEn` sampled at edge E0. `romRd` and `romAddr` are high in the cycle after E0. The ROM samples at E1. `romData` is captured at edge E1+`ROM_LATENCY`. The new `bitDisp` is visible after that edge.
- Total latency from `readEn` to new row is `ROM_LATENCY`+1 edges. For a blank request it is 1 edge.
- `romAddr` is held stable from ISSUE until the next ISSUE.
- `readEn` in the same cycle as LOAD: the request goes to the pending slot and is issued on the next cycle. No overrun.
- Reset asserted mid-fetch: outputs return to reset values immediately. A later `romData` return is ignored.
- `colCnt` changes take effect on `bitDisp` in the same cycle, with zero latency.

## Test plan
- Reset, then `readEn` with charCode=7'h41, rowCnt=3, ROM returns 8'hA5 (`ROM_LATENCY`=1) -> `romAddr`=11'h413 and `romRd` high for exactly 1 cycle. `bitDisp` for colCnt 0..7 = 1,0,1,0,0,1,0,1 starting 2 edges after `readEn`. `rowValid`=1.
- Same request with `invert`=1 -> `bitDisp` = 0,1,0,1,1,0,1,0. Then rowCnt=12 with `invert`=1 -> `bitDisp`=0 for all columns and `romRd` is never asserted.
- `ROM_LATENCY`=3, second `readEn` 1 cycle after the first -> second ROM read issued right after the first LOAD. `overrun`=0. Final active row is the second row's data.
- Three `readEn` strobes on consecutive cycles (`ROM_LATENCY`=3) -> `overrun`=1 and stays 1. The third request is served and the second is never issued.
- Assert `reset` during WAIT -> `rowValid`=0 and `bitDisp`=0 immediately. `romData` arriving afterwards leaves the active row at 0.
- `readEn` with charCode=0 -> no `romRd`. `bitDisp`=0 for all columns one edge later.

Source files
------------

// File: rtl/char_bitmap_server.sv
// Glyph-row server: fetches one font ROM row per request, buffers it, and returns the pixel bit for colCnt.
// Latency ROM_LATENCY+1 edges (1 edge for blank rows); one pending request slot, newest wins, sticky overrun.
`timescale 1ns/1ps
module char_bitmap_server #(
  parameter int ROM_LATENCY = 1,
  parameter int CHAR_ROWS   = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        readEn,
  input  logic [3:0]  rowCnt,
  input  logic [2:0]  colCnt,
  input  logic [6:0]  charCode,
  input  logic        invert,
  input  logic [7:0]  romData,
  output logic        romRd,
  output logic [10:0] romAddr,
  output logic        bitDisp,
  output logic        rowValid,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_LOAD} state_t;

  localparam logic [1:0] LAST_CNT = (ROM_LATENCY > 1) ? 2'(ROM_LATENCY - 2) : 2'd0;

  state_t      r_state, w_next;
  logic [10:0] r_req, r_pend, r_addr;
  logic        r_pend_v;
  logic [1:0]  r_cnt;
  logic [7:0]  r_row;
  logic        r_blank, r_valid, r_ovr;

  logic [10:0] w_new, w_next_req;
  logic        w_new_blank, w_req_blank, w_done, w_start_idle, w_start_chain, w_go_issue, w_pix;

  function automatic logic is_blank(input logic [10:0] req);
    return (req[10:4] == 7'd0) || (32'(req[3:0]) >= CHAR_ROWS);
  endfunction

  assign w_new         = {charCode, rowCnt};
  assign w_new_blank   = is_blank(w_new);
  assign w_req_blank   = is_blank(r_req);
  // A blank request that reached ISSUE (via pending/chaining) completes there without touching the ROM.
  assign w_done        = (r_state == S_LOAD) || ((r_state == S_ISSUE) && w_req_blank);
  assign w_start_idle  = (r_state == S_IDLE) && readEn && !w_new_blank;
  assign w_start_chain = w_done && (readEn || r_pend_v);
  assign w_go_issue    = w_start_idle || w_start_chain;
  assign w_next_req    = (r_state == S_IDLE) ? w_new : (readEn ? w_new : r_pend);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    romRd  = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_idle) w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_req_blank) begin
          w_next = w_start_chain ? S_ISSUE : S_IDLE;
        end else begin
          romRd  = 1'b1;
          w_next = (ROM_LATENCY == 1) ? S_LOAD : S_WAIT;
        end
      end
      S_WAIT:  if (r_cnt == LAST_CNT) w_next = S_LOAD;
      S_LOAD:  w_next = w_start_chain ? S_ISSUE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_row    <= '0;
      r_blank  <= 1'b0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_go_issue) begin
        r_req <= w_next_req;
        if (!is_blank(w_next_req)) r_addr <= w_next_req;
      end
      if ((r_state == S_IDLE) && readEn && w_new_blank) begin
        r_row   <= 8'h00;
        r_blank <= 1'b1;
        r_valid <= 1'b1;
      end
      if (w_done) begin
        r_valid <= 1'b1;
        if (r_state == S_LOAD) begin
          r_row   <= romData;
          r_blank <= 1'b0;
        end else begin
          r_row   <= 8'h00;
          r_blank <= 1'b1;
        end
        // A request arriving at completion is issued directly; an older pending one is dropped.
        r_pend_v <= 1'b0;
        if (readEn && r_pend_v) r_ovr <= 1'b1;
      end else if ((r_state != S_IDLE) && readEn) begin
        r_pend   <= w_new;
        r_pend_v <= 1'b1;
        if (r_pend_v) r_ovr <= 1'b1;
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 2'd1;
    end
  end

  assign romAddr  = r_addr;
  assign rowValid = r_valid;
  assign overrun  = r_ovr;
  assign w_pix    = r_row[3'd7 - colCnt];
  assign bitDisp  = r_valid & (w_pix ^ (invert & ~r_blank));

endmodule

// File: tb/tb_char_bitmap_server.sv
// Bench for char_bitmap_server: two instances (ROM latency 1 and 3) share stimulus; a request-level model
// predicts ROM reads (scoreboard queues) and the visible row state checked every cycle.
`timescale 1ns/1ps
module tb_char_bitmap_server;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       readEn = 1'b0;
  logic [3:0] rowCnt = '0;
  logic [2:0] colCnt = '0;
  logic [6:0] charCode = '0;
  logic       invert = 1'b0;

  logic        rom_rd   [2];
  logic [10:0] rom_addr [2];
  logic [7:0]  rom_data [2];
  logic        bit_disp [2];
  logic        row_valid[2];
  logic        ovr      [2];

  int tests = 0;
  int fails = 0;

  always #10 clock = ~clock;

  char_bitmap_server #(.ROM_LATENCY(1), .CHAR_ROWS(12)) u_l1 (
    .clock(clock), .reset(reset), .readEn(readEn), .rowCnt(rowCnt), .colCnt(colCnt),
    .charCode(charCode), .invert(invert), .romData(rom_data[0]), .romRd(rom_rd[0]),
    .romAddr(rom_addr[0]), .bitDisp(bit_disp[0]), .rowValid(row_valid[0]), .overrun(ovr[0]));

  char_bitmap_server #(.ROM_LATENCY(3), .CHAR_ROWS(12)) u_l3 (
    .clock(clock), .reset(reset), .readEn(readEn), .rowCnt(rowCnt), .colCnt(colCnt),
    .charCode(charCode), .invert(invert), .romData(rom_data[1]), .romRd(rom_rd[1]),
    .romAddr(rom_addr[1]), .bitDisp(bit_disp[1]), .rowValid(row_valid[1]), .overrun(ovr[1]));

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    if (a == 11'h413) return 8'hA5;
    return (a[7:0] * 8'd29) ^ {1'b0, a[10:4]};
  endfunction

  function automatic logic blank_req(input logic [10:0] r);
    return (r[10:4] == 7'd0) || (r[3:0] >= 4'd12);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Font ROM: data for a read sampled at edge E appears after edge E+lat-1; garbage otherwise.
  logic [7:0] pipe [2][4];
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      for (int s = 3; s > 0; s--) pipe[k][s] = pipe[k][s-1];
      pipe[k][0] = rom_rd[k] ? rom_fn(rom_addr[k]) : 8'($urandom);
    end
    #1;
    rom_data[0] = pipe[0][0];
    rom_data[1] = pipe[1][2];
  end

  // Reference model: a server that is busy until a completion time, plus a one-deep newest-wins slot.
  logic        m_busy[2], m_pv[2], m_valid[2], m_blank[2], m_ovr[2], m_cur_bl[2];
  logic [10:0] m_cur[2], m_pend[2];
  logic [7:0]  m_row[2];
  int          m_done[2];
  int          t;
  logic [10:0] q0[$];
  logic [10:0] q1[$];

  task automatic m_start(input int k, input logic [10:0] r, input bit chained);
    if (blank_req(r) && !chained) begin
      m_row[k] = 8'h00; m_blank[k] = 1'b1; m_valid[k] = 1'b1;
    end else begin
      m_busy[k]   = 1'b1;
      m_cur[k]    = r;
      m_cur_bl[k] = blank_req(r);
      m_done[k]   = t + 1 + (blank_req(r) ? 0 : lat(k));
      if (!blank_req(r)) begin
        if (k == 0) q0.push_back(r);
        else        q1.push_back(r);
      end
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      t = 0;
      q0.delete(); q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_pv[k] = 0; m_valid[k] = 0; m_blank[k] = 0; m_ovr[k] = 0;
        m_cur_bl[k] = 0; m_cur[k] = '0; m_pend[k] = '0; m_row[k] = '0; m_done[k] = 0;
      end
    end else begin
      logic [10:0] nr;
      t++;
      nr = {charCode, rowCnt};
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k] && t == m_done[k]) begin
          m_row[k]   = m_cur_bl[k] ? 8'h00 : rom_fn(m_cur[k]);
          m_blank[k] = m_cur_bl[k];
          m_valid[k] = 1'b1;
          m_busy[k]  = 1'b0;
          if (readEn) begin
            if (m_pv[k]) m_ovr[k] = 1'b1;
            m_pv[k] = 1'b0;
            m_start(k, nr, 1'b1);
          end else if (m_pv[k]) begin
            m_pv[k] = 1'b0;
            m_start(k, m_pend[k], 1'b1);
          end
        end else if (m_busy[k]) begin
          if (readEn) begin
            if (m_pv[k]) m_ovr[k] = 1'b1;
            m_pend[k] = nr;
            m_pv[k]   = 1'b1;
          end
        end else if (readEn) begin
          m_start(k, nr, 1'b0);
        end
      end
    end
  end

  // Monitor: pops expected ROM reads on romRd, then sweeps colCnt within the low clock phase.
  always @(negedge clock) begin : mon
    logic [10:0] ea;
    logic        e;
    for (int k = 0; k < 2; k++) begin
      if (rom_rd[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          check($sformatf("L%0d unexpected romRd", lat(k)), 32'(rom_rd[k]), 32'(0));
        end else begin
          if (k == 0) ea = q0.pop_front();
          else        ea = q1.pop_front();
          check($sformatf("L%0d romAddr", lat(k)), 32'(rom_addr[k]), 32'(ea));
        end
      end
      check($sformatf("L%0d rowValid", lat(k)), 32'(row_valid[k]), 32'(m_valid[k]));
      check($sformatf("L%0d overrun", lat(k)), 32'(ovr[k]), 32'(m_ovr[k]));
    end
    for (int c = 0; c < 8; c++) begin
      colCnt = 3'(c);
      #1;
      for (int k = 0; k < 2; k++) begin
        e = m_valid[k] & (m_row[k][7-c] ^ (invert & ~m_blank[k]));
        check($sformatf("L%0d bitDisp col%0d", lat(k), c), 32'(bit_disp[k]), 32'(e));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic strobe(input logic [6:0] ch, input logic [3:0] row);
    readEn = 1'b1; charCode = ch; rowCnt = row;
    @(posedge clock);
    #1;
    readEn = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("L%0d rowValid in reset", lat(k)), 32'(row_valid[k]), 32'(0));
      check($sformatf("L%0d bitDisp in reset", lat(k)), 32'(bit_disp[k]), 32'(0));
      check($sformatf("L%0d romRd in reset", lat(k)), 32'(rom_rd[k]), 32'(0));
    end
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    idle(3);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("L%0d reset romAddr", lat(k)), 32'(rom_addr[k]), 32'(0));
      check($sformatf("L%0d reset overrun", lat(k)), 32'(ovr[k]), 32'(0));
    end
    reset = 1'b0;
    idle(2);

    // Basic fetch: 'A' row 3 -> address 0x413, one-cycle read strobe.
    strobe(7'h41, 4'd3);
    check("L1 romRd in ISSUE", 32'(rom_rd[0]), 32'(1));
    check("L1 romAddr 0x413", 32'(rom_addr[0]), 32'h413);
    idle(1);
    check("L1 romRd one cycle", 32'(rom_rd[0]), 32'(0));
    idle(6);

    // Inverted row, then a beyond-glyph row with invert still set.
    invert = 1'b1;
    strobe(7'h41, 4'd3);
    idle(6);
    strobe(7'h41, 4'd12);
    idle(4);
    invert = 1'b0;

    // Back-to-back requests: second waits in the slot, no overrun.
    strobe(7'h22, 4'd5);
    strobe(7'h23, 4'd6);
    idle(12);
    check("L3 overrun after two", 32'(ovr[1]), 32'(0));

    // Three in a row: middle one is dropped.
    strobe(7'h30, 4'd1);
    strobe(7'h31, 4'd2);
    strobe(7'h32, 4'd4);
    idle(14);
    check("L3 overrun after three", 32'(ovr[1]), 32'(1));

    // Reset during WAIT of the latency-3 instance.
    do_reset();
    idle(2);
    strobe(7'h45, 4'd7);
    idle(1);
    do_reset();
    idle(6);

    // Space character: blank without a ROM read.
    strobe(7'h00, 4'd5);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      invert = 1'($urandom);
      if ($urandom_range(0, 2) == 0)
        strobe(($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom), 4'($urandom));
      else
        idle(1);
    end
    idle(20);
    check("L1 outstanding ROM reads", 32'(q0.size()), 32'(0));
    check("L3 outstanding ROM reads", 32'(q1.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
